// File: rtl/unidade_controle_rodadas_if.sv
// Handshake bundle between the round controller and the memory-game datapath.
// master: the controller (consumes status, drives commands).
// slave:  the datapath side (drives status, consumes commands).
interface unidade_controle_rodadas_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim_endereco;
    logic       fim_rodada;
    logic       fim_timer;
    logic       fim_mostra;

    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       zera_timer;
    logic       conta_timer;
    logic       zera_mostra;
    logic       conta_mostra;
    logic       mostra_led;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, fim_endereco, fim_rodada, fim_timer, fim_mostra,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR,
               zera_timer, conta_timer, zera_mostra, conta_mostra,
               mostra_led, acertou, errou, timeout, pronto, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, fim_endereco, fim_rodada, fim_timer, fim_mostra,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
               zera_timer, conta_timer, zera_mostra, conta_mostra,
               mostra_led, acertou, errou, timeout, pronto, db_estado
    );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// Round controller for the memory game: shows the stored sequence up to the
// current limit, then collects and checks the player's plays, advancing the
// limit after each correct round.
// Optional feature: define TIMEOUT_EN to enable the play-timer timeout path.
// GAP_CYCLES (1..255) sets the LEDs-off gap between displayed items.
module unidade_controle_rodadas #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    unidade_controle_rodadas_if.master    bus
);

    localparam int unsigned GAP_W = 8;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_inicia_rodada  = 4'h2,
        st_mostra         = 4'h3,
        st_apaga          = 4'h4,
        st_proximo_mostra = 4'h5,
        st_zera_endereco  = 4'h6,
        st_espera         = 4'h7,
        st_registra       = 4'h8,
        st_comparacao     = 4'h9,
        st_acertou        = 4'hA,
        st_proxima_jogada = 4'hB,
        st_proxima_rodada = 4'hC,
        st_timeout        = 4'hD,
        st_errou          = 4'hE
    } estado_t;

    estado_t          estado;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_fim;

    assign gap_fim = (gap_cnt == GAP_LAST);

`ifndef TIMEOUT_EN
    logic unused_fim_timer;
    assign unused_fim_timer = bus.fim_timer;
`endif

    // State register with next-state selection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= st_inicial;
        end else begin
            case (estado)
                st_inicial:        if (bus.iniciar) estado <= st_preparacao;
                st_preparacao:     estado <= st_inicia_rodada;
                st_inicia_rodada:  estado <= st_mostra;
                st_mostra:         if (bus.fim_mostra) estado <= st_apaga;
                st_apaga: begin
                    if (gap_fim) begin
                        if (bus.fim_endereco) estado <= st_zera_endereco;
                        else                  estado <= st_proximo_mostra;
                    end
                end
                st_proximo_mostra: estado <= st_mostra;
                st_zera_endereco:  estado <= st_espera;
                st_espera: begin
`ifdef TIMEOUT_EN
                    if (bus.fim_timer)   estado <= st_timeout;
                    else if (bus.jogada) estado <= st_registra;
`else
                    if (bus.jogada)      estado <= st_registra;
`endif
                end
                st_registra:       estado <= st_comparacao;
                st_comparacao: begin
                    if (!bus.igual)             estado <= st_errou;
                    else if (!bus.fim_endereco) estado <= st_proxima_jogada;
                    else if (!bus.fim_rodada)   estado <= st_proxima_rodada;
                    else                        estado <= st_acertou;
                end
                st_proxima_jogada: estado <= st_espera;
                st_proxima_rodada: estado <= st_inicia_rodada;
                st_timeout, st_errou, st_acertou:
                                   if (bus.iniciar) estado <= st_preparacao;
                default:           estado <= st_inicial;
            endcase
        end
    end

    // Gap counter: runs only while the LEDs are blanked between items.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  gap_cnt <= '0;
        else if (estado == st_apaga) gap_cnt <= gap_cnt + GAP_W'(1);
        else                        gap_cnt <= '0;
    end

    // Moore output decode straight from the state register.
    always_comb begin
        bus.zeraE        = 1'b0;
        bus.contaE       = 1'b0;
        bus.zeraL        = 1'b0;
        bus.contaL       = 1'b0;
        bus.zeraR        = 1'b0;
        bus.registraR    = 1'b0;
        bus.zera_timer   = 1'b0;
        bus.conta_timer  = 1'b0;
        bus.zera_mostra  = 1'b0;
        bus.conta_mostra = 1'b0;
        bus.mostra_led   = 1'b0;
        bus.acertou      = 1'b0;
        bus.errou        = 1'b0;
        bus.timeout      = 1'b0;
        bus.pronto       = 1'b0;
        bus.db_estado    = 4'(estado);
        case (estado)
            st_inicial: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
            end
            st_preparacao: begin
                bus.zeraE       = 1'b1;
                bus.zeraL       = 1'b1;
                bus.zeraR       = 1'b1;
                bus.zera_timer  = 1'b1;
                bus.zera_mostra = 1'b1;
            end
            st_inicia_rodada: begin
                bus.zeraE       = 1'b1;
                bus.zera_mostra = 1'b1;
            end
            st_mostra: begin
                bus.mostra_led   = 1'b1;
                bus.conta_mostra = 1'b1;
            end
            st_apaga:          bus.zera_mostra = 1'b1;
            st_proximo_mostra: bus.contaE = 1'b1;
            st_zera_endereco: begin
                bus.zeraE      = 1'b1;
                bus.zera_timer = 1'b1;
            end
            st_espera: begin
`ifdef TIMEOUT_EN
                bus.conta_timer = 1'b1;
`endif
            end
            st_registra:       bus.registraR = 1'b1;
            st_comparacao:     ;
            st_proxima_jogada: begin
                bus.contaE     = 1'b1;
                bus.zera_timer = 1'b1;
            end
            st_proxima_rodada: begin
                bus.contaL     = 1'b1;
                bus.zera_timer = 1'b1;
            end
            st_timeout: begin
`ifdef TIMEOUT_EN
                bus.timeout = 1'b1;
`endif
                bus.pronto  = 1'b1;
            end
            st_errou: begin
                bus.errou  = 1'b1;
                bus.pronto = 1'b1;
            end
            st_acertou: begin
                bus.acertou = 1'b1;
                bus.pronto  = 1'b1;
            end
            default:           bus.db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for the round controller: a small behavioural datapath (4-word memory,
// address/limit counters, play register, display and play timers) answers the
// controller's commands; a player model plays random memory contents.
module tb_unidade_controle_rodadas;

    localparam int unsigned GAP        = 2;
    localparam int          MOSTRA_LEN = 3;
    localparam int          TLIM       = 40;
    localparam int          BUDGET     = 300;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    unidade_controle_rodadas_if bus ();

    unidade_controle_rodadas #(.GAP_CYCLES(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath model state.
    logic [3:0] mem [4];
    int         e_cnt  = 0;
    int         l_cnt  = 0;
    logic [3:0] r_reg  = 4'h0;
    int         cnt_m  = 0;
    int         cnt_t  = 0;
    logic       fim_force;
    logic [3:0] play_val;

    // Observation counters.
    int         n_contaL = 0;
    int         n_regR   = 0;
    logic       led_prev = 1'b0;
    logic [3:0] disp_q [$];

    int total = 0;
    int bad   = 0;

    // Datapath registers follow the controller's commands.
    always @(posedge clock) begin
        if (bus.zeraE)             e_cnt <= 0;
        else if (bus.contaE)       e_cnt <= e_cnt + 1;
        if (bus.zeraL)             l_cnt <= 0;
        else if (bus.contaL)       l_cnt <= l_cnt + 1;
        if (bus.zeraR)             r_reg <= 4'h0;
        else if (bus.registraR)    r_reg <= play_val;
        if (bus.zera_mostra)       cnt_m <= 0;
        else if (bus.conta_mostra) cnt_m <= cnt_m + 1;
        if (bus.zera_timer)        cnt_t <= 0;
        else if (bus.conta_timer)  cnt_t <= cnt_t + 1;
    end

    assign bus.igual        = (r_reg == mem[e_cnt[1:0]]);
    assign bus.fim_endereco = (e_cnt == l_cnt);
    assign bus.fim_rodada   = (l_cnt == 3);
    assign bus.fim_mostra   = (cnt_m == MOSTRA_LEN - 1);
    assign bus.fim_timer    = fim_force || (cnt_t >= TLIM);

    // Record every command pulse and every item shown on the LEDs.
    always @(posedge clock) begin
        if (bus.contaL)    n_contaL <= n_contaL + 1;
        if (bus.registraR) n_regR   <= n_regR + 1;
        if (bus.mostra_led && !led_prev) disp_q.push_back(mem[e_cnt[1:0]]);
        led_prev <= bus.mostra_led;
    end

    function automatic logic [14:0] outs();
        return {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR, bus.registraR,
                bus.zera_timer, bus.conta_timer, bus.zera_mostra, bus.conta_mostra,
                bus.mostra_led, bus.acertou, bus.errou, bus.timeout, bus.pronto};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input string tag);
        int n;
        n = 0;
        while (bus.db_estado !== s && n < BUDGET) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.db_estado), 32'(s));
    endtask

    // Player for round k (k+1 plays); wrong_at selects the play to miss, -1 for none.
    task automatic play_round(input int k, input int wrong_at);
        logic [3:0] expn;
        for (int j = 0; j <= k; j++) begin
            wait_state(4'h7, "wait_espera");
            repeat ($urandom_range(0, 2)) tick();
            play_val   = (j == wrong_at) ? ~mem[j] : mem[j];
            bus.jogada = 1'b1;
            tick();
            bus.jogada = 1'b0;
            chk("registra", 32'(bus.db_estado), 32'h8);
            tick();
            chk("comparacao", 32'(bus.db_estado), 32'h9);
            tick();
            if (j == wrong_at) begin
                chk("errou_state", 32'(bus.db_estado), 32'hE);
                return;
            end
            if (j < k)      expn = 4'hB;
            else if (k < 3) expn = 4'hC;
            else            expn = 4'hA;
            chk("after_compare", 32'(bus.db_estado), 32'(expn));
        end
    endtask

    initial begin
        int base_l;
        int base_q;
        int base_r;
        int nm;
        int na;
        int idx;
        int devs;

        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.jogada  = 1'b0;
        fim_force   = 1'b0;
        play_val    = 4'h0;
        for (int i = 0; i < 4; i++) mem[i] = 4'($urandom());

        #2;
        chk("reset_state", 32'(bus.db_estado), 32'h0);
        chk("reset_outs", 32'(outs()), 32'(15'b101010000000000));
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_state", 32'(bus.db_estado), 32'h0);

        // First game: directed look at the display phase, then play all four rounds.
        base_l = n_contaL;
        base_q = disp_q.size();
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        chk("prep_state", 32'(bus.db_estado), 32'h1);
        chk("prep_outs", 32'(outs()), 32'(15'b101010101000000));
        tick();
        chk("inicia_state", 32'(bus.db_estado), 32'h2);
        tick();
        chk("mostra_state", 32'(bus.db_estado), 32'h3);
        nm = 0;
        while (bus.db_estado == 4'h3 && nm < 20) begin
            if (bus.mostra_led) nm++;
            tick();
        end
        chk("mostra_cycles", 32'(nm), 32'(MOSTRA_LEN));
        na = 0;
        while (bus.db_estado == 4'h4 && na < 20) begin
            if (!bus.mostra_led) na++;
            tick();
        end
        chk("apaga_cycles", 32'(na), 32'(GAP));
        chk("zera_end_state", 32'(bus.db_estado), 32'h6);

        for (int k = 0; k < 4; k++) play_round(k, -1);
        chk("acertou_state", 32'(bus.db_estado), 32'hA);
        chk("acertou_flag", 32'(bus.acertou), 32'h1);
        chk("acertou_pronto", 32'(bus.pronto), 32'h1);
        chk("contaL_count", 32'(n_contaL - base_l), 32'd3);
        chk("disp_count", 32'(disp_q.size() - base_q), 32'd10);
        idx = base_q;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j <= k; j++) begin
                if (idx < disp_q.size()) chk("disp_item", 32'(disp_q[idx]), 32'(mem[j]));
                idx++;
            end
        end
        tick();
        chk("acertou_hold", 32'(bus.db_estado), 32'hA);

        // Second game: miss the second play of round 2.
        for (int i = 0; i < 4; i++) mem[i] = 4'($urandom());
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        chk("restart_state", 32'(bus.db_estado), 32'h1);
        play_round(0, -1);
        play_round(1, 1);
        chk("errou_flag", 32'(bus.errou), 32'h1);
        chk("errou_pronto", 32'(bus.pronto), 32'h1);
        chk("errou_acertou", 32'(bus.acertou), 32'h0);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        chk("errou_restart_state", 32'(bus.db_estado), 32'h1);
        chk("errou_restart_outs", 32'(outs()), 32'(15'b101010101000000));

        // Button pulses during the display phase must not move the FSM.
        base_r = n_regR;
        tick();
        tick();
        chk("mostra_again", 32'(bus.db_estado), 32'h3);
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        chk("jogada_in_mostra", 32'(bus.db_estado), 32'h3);
        wait_state(4'h4, "wait_apaga");
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        chk("jogada_in_apaga", 32'(bus.db_estado), 32'h4);
        wait_state(4'h7, "wait_espera_t");
        chk("no_register_in_display", 32'(n_regR - base_r), 32'd0);

`ifdef TIMEOUT_EN
        // Timer expiry wins over a simultaneous play.
        base_r      = n_regR;
        fim_force   = 1'b1;
        bus.jogada  = 1'b1;
        tick();
        bus.jogada  = 1'b0;
        fim_force   = 1'b0;
        chk("timeout_state", 32'(bus.db_estado), 32'hD);
        chk("timeout_flag", 32'(bus.timeout), 32'h1);
        chk("timeout_pronto", 32'(bus.pronto), 32'h1);
        tick();
        chk("timeout_hold", 32'(bus.db_estado), 32'hD);
        chk("timeout_no_registra", 32'(n_regR - base_r), 32'd0);
`else
        // Without the timeout path the expiry input is ignored.
        fim_force = 1'b1;
        devs      = 0;
        repeat (100) begin
            tick();
            if (bus.db_estado !== 4'h7 || bus.conta_timer !== 1'b0) devs++;
        end
        chk("espera_ignores_timer", 32'(devs), 32'd0);
        chk("timeout_off", 32'(bus.timeout), 32'h0);
        bus.jogada = 1'b1;
        tick();
        bus.jogada = 1'b0;
        fim_force  = 1'b0;
        chk("jogada_after_timer", 32'(bus.db_estado), 32'h8);
`endif

        // Asynchronous reset in the middle of the display phase.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_again", 32'(bus.db_estado), 32'h0);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        wait_state(4'h3, "wait_mostra_rst");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(bus.db_estado), 32'h0);
        chk("async_reset_outs", 32'(outs()), 32'(15'b101010000000000));
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_idle", 32'(bus.db_estado), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
